// File: rtl/byte_serial_add_ctrl_if.sv
// Requester-side handshake bundle for the byte-serial add/subtract controller.
// The requester drives operands and start; the controller returns status and result.
interface byte_serial_add_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// Sequences a shared combinational 8-bit adder to build an NBYTES*8-bit add/subtract,
// one byte per clock, LSB first, chaining the carry through a register.
module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  byte_serial_add_ctrl_if.slave rq,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;
  logic            overflow_q, overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      done_q     <= done_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    done_d     = 1'b0;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (rq.start) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
          a_d      = rq.a_in;
          b_d      = rq.sub ? ~rq.b_in : rq.b_in;
          carry_d  = rq.sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[8*idx_q +: 8] = add_s;
        carry_d                = add_cout;
        if (idx_q == LAST_IDX) begin
          // b_q already holds ~B for subtraction, so one overflow rule covers both ops.
          cout_d     = add_cout;
          overflow_d = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[8*idx_q +: 8];
      add_b   = b_q[8*idx_q +: 8];
      add_cin = carry_q;
    end
  end

  assign rq.busy     = (state_q == RUN);
  assign rq.done     = done_q;
  assign rq.result   = result_q;
  assign rq.cout     = cout_q;
  assign rq.overflow = overflow_q;
endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed bench for byte_serial_add_ctrl (NBYTES=4) paired with a behavioural 8-bit adder.
module tb_byte_serial_add_ctrl;
  localparam int NBYTES = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] add_a, add_b, add_s;
  logic       add_cin, add_cout;
  int         tests  = 0;
  int         failed = 0;
  int         lat, bcnt;

  byte_serial_add_ctrl_if #(.NBYTES(NBYTES)) rq ();

  byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rq       (rq.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // The shared external ripple adder: zero-latency combinational.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    rq.start = 1'b1;
    rq.sub   = s;
    rq.a_in  = a;
    rq.b_in  = b;
    @(negedge clk);
    rq.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, input int bcnt0, output int l, output int bc);
    l  = lat0;
    bc = bcnt0;
    while (!rq.done && l < 20) begin
      if (rq.busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er,
                           input logic ec, input logic eo);
    int l, bc;
    issue(s, a, b);
    wait_done(1, 0, l, bc);
    chk({tag, "_lat"},  l, 5);
    chk({tag, "_busy"}, bc, 4);
    chk({tag, "_res"},  rq.result, er);
    chk({tag, "_cout"}, {31'd0, rq.cout}, {31'd0, ec});
    chk({tag, "_ovf"},  {31'd0, rq.overflow}, {31'd0, eo});
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    rq.start = 1'b0;
    rq.sub   = 1'b0;
    rq.a_in  = '0;
    rq.b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, rq.busy}, 0);
    chk("rst_done",   {31'd0, rq.done}, 0);
    chk("rst_result", rq.result, 0);
    chk("rst_cout",   {31'd0, rq.cout}, 0);
    chk("rst_ovf",    {31'd0, rq.overflow}, 0);
    chk("rst_adder",  {15'd0, add_a, add_b, add_cin}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: carry ripples from byte 0 into byte 1; latency and pulse width.
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001);
    chk("t1_cin_b0", {31'd0, add_cin}, 0);
    chk("t1_a_b0",   {24'd0, add_a}, 32'hFF);
    @(negedge clk);
    chk("t1_cin_b1", {31'd0, add_cin}, 1);
    chk("t1_a_b1",   {24'd0, add_a}, 0);
    wait_done(2, 1, lat, bcnt);
    chk("t1_lat",  lat, 5);
    chk("t1_busy", bcnt, 4);
    chk("t1_res",  rq.result, 32'h0000_0100);
    chk("t1_cout", {31'd0, rq.cout}, 0);
    chk("t1_ovf",  {31'd0, rq.overflow}, 0);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, rq.done}, 0);
    chk("t1_res_held",   rq.result, 32'h0000_0100);
    chk("t1_idle_adder", {15'd0, add_a, add_b, add_cin}, 0);

    // Tests 2-4: carry, overflow and subtraction boundaries.
    run_check("t2_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run_check("t3_posovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    run_check("t3_negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    run_check("t4_5m7",    1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_check("t4_7m5",    1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0);
    run_check("t4_minm1",  1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Test 5a: start re-pulsed in cycle 2 of RUN with different operands is ignored.
    issue(1'b0, 32'h0000_0003, 32'h0000_0004);
    @(negedge clk);
    rq.start = 1'b1;
    rq.sub   = 1'b1;
    rq.a_in  = 32'hAAAA_AAAA;
    rq.b_in  = 32'h1111_1111;
    @(negedge clk);
    rq.start = 1'b0;
    wait_done(3, 2, lat, bcnt);
    chk("t5_ign_lat",  lat, 5);
    chk("t5_ign_busy", bcnt, 4);
    chk("t5_ign_res",  rq.result, 32'h0000_0007);
    chk("t5_ign_cout", {31'd0, rq.cout}, 0);

    // Test 5b: start during the done cycle is accepted back-to-back.
    rq.start = 1'b1;
    rq.sub   = 1'b0;
    rq.a_in  = 32'h0101_0101;
    rq.b_in  = 32'h1010_1010;
    @(negedge clk);
    rq.start = 1'b0;
    chk("t5_b2b_done0", {31'd0, rq.done}, 0);
    chk("t5_b2b_busy",  {31'd0, rq.busy}, 1);
    chk("t5_b2b_clr",   rq.result, 0);
    wait_done(1, 0, lat, bcnt);
    chk("t5_b2b_lat", lat, 5);
    chk("t5_b2b_res", rq.result, 32'h1111_1111);
    @(negedge clk);

    run_check("t6_pre", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Test 6: asynchronous reset after byte 1 aborts the operation.
    issue(1'b0, 32'h1234_5678, 32'h1111_1111);
    @(negedge clk);
    chk("t6_partial", rq.result, 32'h0000_0089);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",   {31'd0, rq.busy}, 0);
    chk("t6_rst_done",   {31'd0, rq.done}, 0);
    chk("t6_rst_result", rq.result, 0);
    chk("t6_rst_cout",   {31'd0, rq.cout}, 0);
    chk("t6_rst_ovf",    {31'd0, rq.overflow}, 0);
    chk("t6_rst_adder",  {15'd0, add_a, add_b, add_cin}, 0);
    @(negedge clk);
    chk("t6_rst_idle", {31'd0, rq.busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", {31'd0, rq.busy}, 0);
    run_check("t6_after", 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
